// File: rtl/spi_conf_regs.sv
// SPI slave holding a bank of configuration registers, oversampled on pck0.
// Frames are MSB first (rw, address, data); writes commit once per complete frame.
module spi_conf_regs #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 2,
    parameter int                NREGS       = 4,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                    pck0,
    input  logic                    reset,
    input  logic                    spck,
    input  logic                    mosi,
    input  logic                    ncs,
    output logic                    miso,
    output logic [NREGS*DATA_W-1:0] conf_flat,
    output logic                    conf_update,
    output logic [ADDR_W-1:0]       conf_addr
);
    timeunit 1ns;
    timeprecision 1ps;

    localparam int HDR_LEN   = 1 + ADDR_W;
    localparam int FRAME_LEN = HDR_LEN + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] spck_sync_q, spck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
    logic                   spck_prev_q, spck_prev_d;
    logic                   ncs_prev_q,  ncs_prev_d;

    logic spck_s;
    logic mosi_s;
    logic ncs_s;
    logic spck_rise;
    logic spck_fall;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [HDR_LEN-1:0]  hdr_q,   hdr_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [DATA_W-1:0]   rd_q,    rd_d;
    logic                miso_q,  miso_d;
    logic                upd_q,   upd_d;
    logic [ADDR_W-1:0]   caddr_q, caddr_d;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   regs_d [NREGS];

    logic [HDR_LEN-1:0]  hdr_next;
    logic [DATA_W-1:0]   data_next;
    logic [ADDR_W-1:0]   next_addr;
    logic [ADDR_W-1:0]   frame_addr;
    logic                frame_rw;
    logic                frame_addr_ok;
    logic [DATA_W-1:0]   rd_word;

    // Synchroniser chains shift toward the top bit; the top bit is the usable value.
    always_comb begin
        spck_sync_d = {spck_sync_q[SYNC_STAGES-2:0], spck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0],  ncs};
    end

    assign spck_s      = spck_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign ncs_s       = ncs_sync_q[SYNC_STAGES-1];
    assign spck_prev_d = spck_s;
    assign ncs_prev_d  = ncs_s;
    assign spck_rise   = spck_s & ~spck_prev_q;
    assign spck_fall   = ~spck_s & spck_prev_q;

    assign hdr_next      = {hdr_q[HDR_LEN-2:0], mosi_s};
    assign data_next     = {data_q[DATA_W-2:0], mosi_s};
    assign next_addr     = hdr_next[ADDR_W-1:0];
    assign frame_rw      = hdr_q[HDR_LEN-1];
    assign frame_addr    = hdr_q[ADDR_W-1:0];
    assign frame_addr_ok = {1'b0, frame_addr} < (ADDR_W+1)'(NREGS);

    // Readback word for the address completing this cycle; unimplemented addresses read zero.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (next_addr == ADDR_W'(k)) begin
                rd_word = regs_q[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        data_d  = data_q;
        rd_d    = rd_q;
        miso_d  = miso_q;
        upd_d   = 1'b0;
        caddr_d = caddr_q;
        regs_d  = regs_q;

        if (ncs_s) begin
            // Deselect at any point abandons the frame, including a pending commit.
            state_d = ST_IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ncs_prev_q) begin
                        state_d = ST_HDR;
                        cnt_d   = '0;
                        hdr_d   = '0;
                        data_d  = '0;
                        rd_d    = '0;
                        miso_d  = 1'b0;
                    end
                end
                ST_HDR: begin
                    if (spck_rise) begin
                        hdr_d = hdr_next;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == HDR_LAST) begin
                            state_d = ST_DATA;
                            rd_d    = rd_word;
                        end
                    end
                end
                ST_DATA: begin
                    if (spck_rise) begin
                        data_d = data_next;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == FRAME_LAST) begin
                            state_d = ST_DONE;
                            if (!frame_rw && frame_addr_ok) begin
                                upd_d   = 1'b1;
                                caddr_d = frame_addr;
                                for (int k = 0; k < NREGS; k++) begin
                                    if (frame_addr == ADDR_W'(k)) begin
                                        regs_d[k] = data_next;
                                    end
                                end
                            end
                        end
                    end else if (spck_fall && frame_rw) begin
                        miso_d = rd_q[DATA_W-1];
                        rd_d   = {rd_q[DATA_W-2:0], 1'b0};
                    end
                end
                ST_DONE: begin
                    if (spck_fall) begin
                        miso_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pck0) begin
        if (reset) begin
            spck_sync_q <= '0;
            mosi_sync_q <= '0;
            ncs_sync_q  <= '1;
            spck_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hdr_q       <= '0;
            data_q      <= '0;
            rd_q        <= '0;
            miso_q      <= 1'b0;
            upd_q       <= 1'b0;
            caddr_q     <= '0;
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
        end else begin
            spck_sync_q <= spck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            spck_prev_q <= spck_prev_d;
            ncs_prev_q  <= ncs_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            miso_q      <= miso_d;
            upd_q       <= upd_d;
            caddr_q     <= caddr_d;
            regs_q      <= regs_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_flat
            assign conf_flat[gi*DATA_W +: DATA_W] = regs_q[gi];
        end
    endgenerate

    assign miso        = miso_q;
    assign conf_update = upd_q;
    assign conf_addr   = caddr_q;

endmodule

// File: tb/tb_spi_conf_regs.sv
// Bench for spi_conf_regs: default instance plus a 16-bit/5-register instance sharing spck/mosi.
module tb_spi_conf_regs;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int HALF = 80;
    localparam int GAP  = 400;

    logic        pck0 = 1'b0;
    logic        reset;
    logic        spck;
    logic        mosi;
    logic        ncs_a;
    logic        ncs_b;
    logic        miso_a;
    logic        miso_b;
    logic [31:0] conf_flat_a;
    logic [79:0] conf_flat_b;
    logic        conf_update_a;
    logic        conf_update_b;
    logic [1:0]  conf_addr_a;
    logic [2:0]  conf_addr_b;

    typedef struct packed {
        logic [2:0]  addr;
        logic [79:0] flat;
    } exp_t;

    exp_t        wq_a[$];
    exp_t        wq_b[$];
    logic        rdq_a[$];
    logic        rdq_b[$];
    exp_t        ea;
    exp_t        eb;
    logic [31:0] model_a;
    logic [79:0] model_b;
    logic        rd_win;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    spi_conf_regs dut_a (
        .pck0        (pck0),
        .reset       (reset),
        .spck        (spck),
        .mosi        (mosi),
        .ncs         (ncs_a),
        .miso        (miso_a),
        .conf_flat   (conf_flat_a),
        .conf_update (conf_update_a),
        .conf_addr   (conf_addr_a)
    );

    spi_conf_regs #(
        .DATA_W      (16),
        .ADDR_W      (3),
        .NREGS       (5),
        .SYNC_STAGES (3)
    ) dut_b (
        .pck0        (pck0),
        .reset       (reset),
        .spck        (spck),
        .mosi        (mosi),
        .ncs         (ncs_b),
        .miso        (miso_b),
        .conf_flat   (conf_flat_b),
        .conf_update (conf_update_b),
        .conf_addr   (conf_addr_b)
    );

    always #5 pck0 = ~pck0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        fails++;
        $display("FAIL %s: event seen with nothing expected", name);
    endtask

    // Write-commit monitor: every strobe must match the oldest queued expectation.
    always @(negedge pck0) begin
        if (conf_update_a === 1'b1) begin
            if (wq_a.size() == 0) begin
                flag_fail("a_unexpected_strobe");
            end else begin
                ea = wq_a.pop_front();
                chk("a_conf_addr", conf_addr_a, ea.addr[1:0]);
                chk("a_conf_flat", conf_flat_a, ea.flat[31:0]);
                $display("commit A addr=%0d flat=%08h", conf_addr_a, conf_flat_a);
            end
        end
        if (conf_update_b === 1'b1) begin
            if (wq_b.size() == 0) begin
                flag_fail("b_unexpected_strobe");
            end else begin
                eb = wq_b.pop_front();
                chk("b_conf_addr", conf_addr_b, eb.addr);
                chk("b_conf_flat", conf_flat_b, eb.flat);
                $display("commit B addr=%0d flat=%020h", conf_addr_b, conf_flat_b);
            end
        end
    end

    // Readback monitor: the master view of miso at each spck rise.
    always @(posedge spck) begin
        if (ncs_a === 1'b0) begin
            if (rd_win) begin
                if (rdq_a.size() == 0) flag_fail("a_miso_extra_bit");
                else chk("a_miso_bit", miso_a, rdq_a.pop_front());
            end else begin
                chk("a_miso_quiet", miso_a, 1'b0);
            end
        end
        if (ncs_b === 1'b0) begin
            if (rd_win) begin
                if (rdq_b.size() == 0) flag_fail("b_miso_extra_bit");
                else chk("b_miso_bit", miso_b, rdq_b.pop_front());
            end else begin
                chk("b_miso_quiet", miso_b, 1'b0);
            end
        end
    end

    // Drives one SPI frame of nsend spck pulses; pulses beyond the frame carry 1s.
    task automatic frame(input bit sel, input bit rw, input int addr, input int data,
                         input int alen, input int dlen, input int nsend,
                         input logic [15:0] exp_rd);
        int   f;
        logic b;
        f = 1 + alen + dlen;
        if (rw) begin
            for (int j = dlen - 1; j >= 0; j--) begin
                if (sel) rdq_b.push_back(exp_rd[j]);
                else     rdq_a.push_back(exp_rd[j]);
            end
        end
        if (sel) ncs_b = 1'b0;
        else     ncs_a = 1'b0;
        #(HALF);
        for (int i = 0; i < nsend; i++) begin
            if (i == 0)        b = rw;
            else if (i <= alen) b = addr[alen - i];
            else if (i < f)     b = data[dlen - 1 - (i - 1 - alen)];
            else                b = 1'b1;
            mosi   = b;
            rd_win = rw && (i > alen) && (i < f);
            #(HALF);
            spck = 1'b1;
            #(HALF);
            spck = 1'b0;
        end
        rd_win = 1'b0;
        mosi   = 1'b0;
        #(HALF);
        if (sel) ncs_b = 1'b1;
        else     ncs_a = 1'b1;
        #(GAP);
        $display("frame %s rw=%0d addr=%0d data=%0h pulses=%0d", sel ? "B" : "A", rw, addr, data, nsend);
    endtask

    task automatic wr(input bit sel, input int addr, input int data, input int extra);
        exp_t e;
        if (!sel) begin
            if (addr < 4) begin
                model_a[addr*8 +: 8] = data[7:0];
                e.addr = 3'(addr);
                e.flat = {48'd0, model_a};
                wq_a.push_back(e);
            end
            frame(1'b0, 1'b0, addr, data, 2, 8, 11 + extra, 16'h0);
        end else begin
            if (addr < 5) begin
                model_b[addr*16 +: 16] = data[15:0];
                e.addr = 3'(addr);
                e.flat = model_b;
                wq_b.push_back(e);
            end
            frame(1'b1, 1'b0, addr, data, 3, 16, 20 + extra, 16'h0);
        end
    endtask

    task automatic rd(input bit sel, input int addr, input logic [15:0] exp_rd);
        if (!sel) frame(1'b0, 1'b1, addr, 0, 2, 8, 11, exp_rd);
        else      frame(1'b1, 1'b1, addr, 0, 3, 16, 20, exp_rd);
    endtask

    initial begin
        #500us;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        spck    = 1'b0;
        mosi    = 1'b0;
        ncs_a   = 1'b1;
        ncs_b   = 1'b1;
        rd_win  = 1'b0;
        model_a = '0;
        model_b = '0;
        repeat (5) @(posedge pck0);
        #3;
        reset = 1'b0;
        @(negedge pck0);
        chk("a_reset_flat",   conf_flat_a,   32'h0);
        chk("a_reset_miso",   miso_a,        1'b0);
        chk("a_reset_update", conf_update_a, 1'b0);
        chk("a_reset_addr",   conf_addr_a,   2'd0);
        chk("b_reset_flat",   conf_flat_b,   80'h0);
        chk("b_reset_miso",   miso_b,        1'b0);
        chk("b_reset_update", conf_update_b, 1'b0);
        chk("b_reset_addr",   conf_addr_b,   3'd0);
        #3;
        #(GAP);

        wr(1'b0, 0, 'hE0, 0);
        wr(1'b0, 3, 'h5A, 0);
        rd(1'b0, 3, 16'h005A);

        // Deselect after 6 of 11 bits: nothing may change.
        frame(1'b0, 1'b0, 1, 'hFF, 2, 8, 6, 16'h0);
        chk("a_abort_flat", conf_flat_a, 32'h5A0000E0);
        wr(1'b0, 1, 'h11, 0);

        // Three surplus pulses after a complete write still give a single commit.
        wr(1'b0, 2, 'hC3, 3);
        chk("a_extra_flat", conf_flat_a, 32'h5AC311E0);

        wr(1'b0, 0, 'h33, 0);
        fork
            frame(1'b0, 1'b0, 0, 'hAA, 2, 8, 11, 16'h0);
            begin
                #900;
                reset = 1'b1;
                #30;
                reset = 1'b0;
            end
        join
        model_a = '0;
        model_b = '0;
        chk("a_midreset_flat", conf_flat_a, 32'h0);
        chk("a_midreset_addr", conf_addr_a, 2'd0);
        wr(1'b0, 0, 'h42, 0);
        rd(1'b0, 0, 16'h0042);
        rd(1'b0, 2, 16'h0000);

        wr(1'b1, 4, 'hBEEF, 0);
        chk("b_reg4", conf_flat_b[79:64], 16'hBEEF);
        wr(1'b1, 6, 'h1234, 0);
        chk("b_ignored_flat", conf_flat_b, {16'hBEEF, 64'h0});
        rd(1'b1, 6, 16'h0000);
        rd(1'b1, 4, 16'hBEEF);

        chk("a_commits_drained", wq_a.size(), 0);
        chk("b_commits_drained", wq_b.size(), 0);
        chk("a_read_drained",    rdq_a.size(), 0);
        chk("b_read_drained",    rdq_b.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_conf_regs.md
Name: spi_conf_regs

Overview:
- Parametrised successor to the single 8-bit spck-clocked config word: an SPI slave that runs on the system clock and oversamples spck/mosi/ncs through synchronisers.
- Implements a bank of NREGS addressed configuration registers, each DATA_W bits wide, with write and readback over miso.
- Sits between the ARM SPI pins and the mode/carrier logic (lo-freq/hi-freq select, carrier enable, divisors).
- Outputs the whole bank flattened, plus a one-cycle update strobe per committed write.

Parameters:
- DATA_W, 8, width of each config register.
- ADDR_W, 2, width of the address field in a frame.
- NREGS, 4, number of implemented registers (≤ 2**ADDR_W).
- SYNC_STAGES, 2, flip-flop depth of the spck/mosi/ncs synchronisers (≥2).
- RESET_VAL, 0, reset value of every register (DATA_W bits).

Ports:
- pck0  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- spck  input  1  SPI clock, asynchronous to pck0.
- mosi  input  1  SPI data in, asynchronous.
- ncs  input  1  SPI chip select, active low, asynchronous.
- miso  output  1  SPI readback data.
- conf_flat  output  NREGS*DATA_W  all registers; reg k at bits [k*DATA_W +: DATA_W].
- conf_update  output  1  one-cycle pulse when a write commits.
- conf_addr  output  ADDR_W  address of the last committed write; valid with conf_update and held afterwards.

Behaviour:
- Reset: all registers = RESET_VAL, miso=0, conf_update=0, conf_addr=0, FSM=IDLE, bit counter=0, synchronisers flushed to spck=0, ncs=1, mosi=0.
- Synchronisation: each input passes through SYNC_STAGES flops. Edges are detected by comparing the last two synchronised values. Timing requirement: spck high and low phases each ≥ SYNC_STAGES+2 pck0 cycles.
- Frame format, MSB first, bits sampled on spck rising edges while ncs is low:
  - bit 0: rw (1 = read, 0 = write);
  - next ADDR_W bits: address;
  - next DATA_W bits: data (ignored for reads).
  - Frame length F = 1+ADDR_W+DATA_W.
- FSM states:
  - IDLE: on synchronised ncs fall -> HDR, counter=0.
  - HDR: shift rw+address; after the (1+ADDR_W)th rising edge -> DATA.
  - DATA: shift data bits; after the Fth rising edge -> DONE.
  - DONE: ignore further spck edges.
  - Synchronised ncs rise in any state -> IDLE.
- Write commit:
  - Occurs on the pck0 cycle after the Fth rising edge is detected, and only if rw=0 and address < NREGS.
  - Target register updates; conf_update=1 for exactly one cycle; conf_addr=address.
  - Address ≥ NREGS: no update, no strobe.
- Aborted frame: ncs rises before F bits -> discard the frame, no register change, no strobe.
- Extra bits after F: ignored; only one commit per frame.
- Read:
  - On the spck falling edge ending the last address bit, miso = reg[addr][DATA_W-1].
  - Each subsequent falling edge shifts out the next lower bit.
  - The master samples miso on spck rising edges.
  - Address ≥ NREGS reads as all zeros.
  - miso updates within SYNC_STAGES+2 pck0 cycles of the raw spck fall.
  - miso=0 in IDLE, HDR, during write frames, and after the last data bit.
- ncs glitch: ncs high at an edge-detect cycle resets the FSM even mid-bit. A new ncs fall starts a fresh frame.
- Reset mid-frame: immediate return to IDLE, registers reloaded to RESET_VAL, pending commit dropped.
- Simultaneous reset and commit: reset wins.
- conf_flat is purely registered; it changes only on commit or reset.

Test Plan:
- Reset, then write frame rw=0, addr=0, data=8'hE0 (lo-freq, carrier on, 125 kHz) -> conf_flat[7:0]=8'hE0, one conf_update pulse, conf_addr=0; other registers stay 0.
- Write addr=3 data=8'h5A, then read frame rw=1 addr=3 -> miso returns 0,1,0,1,1,0,1,0 on successive rising edges; no conf_update during the read.
- Abort: ncs rises after 6 of 11 bits of a write of 8'hFF to addr=1 -> reg1 unchanged (0), no strobe. The next full frame writing 8'h11 to addr=1 commits correctly.
- Write to addr=2 followed by 3 extra spck pulses before ncs rises -> exactly one conf_update; reg2 holds the first 8 data bits.
- Reset asserted during the data phase of a write of 8'hAA to addr=0 previously holding 8'h33 -> reg0=RESET_VAL (0), no strobe; a subsequent frame works normally.
- Parameter sweep DATA_W=16, ADDR_W=3, NREGS=5, SYNC_STAGES=3:
  - write 16'hBEEF to addr=4 -> conf_flat[79:64]=16'hBEEF;
  - write to addr=6 -> ignored, no strobe;
  - read of addr=6 -> sixteen 0 bits.
